blit_cnt: RTL and testbench



---
 rtl/blit_cnt_pkg.sv | 19 +
 rtl/blit_cnt_dcr.sv | 32 +++
 rtl/blit_cnt.sv | 162 ++++++++++++++++
 tb/tb_blit_cnt.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_cnt_pkg.sv
// Shared types and constants for the blitter loop-count sequencer.
package blit_cnt_pkg;

    // Sequencer states: idle, inner-loop stepping, one-cycle outer advance
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        OUTER = 2'd2
    } state_e;

    // Status word bit positions
    localparam int STAT_IDLE_BIT  = 0;
    localparam int STAT_OUTER_BIT = 1;
    localparam int STAT_CNT_LSB   = 16;

    // Position of the outer count field inside the COUNT write word
    localparam int COUNT_OUTER_LSB = 16;

endpackage

// File: rtl/blit_cnt_dcr.sv
// Loadable down counter used for both the inner and the outer loop count.
// A count of zero behaves as 2**CNT_W: decrementing zero wraps to all-ones.
module blit_cnt_dcr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             ld,
    input  logic             dec,
    input  logic [CNT_W-1:0] d,
    output logic [CNT_W-1:0] q,
    output logic             is_one
);

    logic [CNT_W-1:0] r_q;

    // Counter register: load wins over decrement
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (dec) begin
            r_q <= r_q - CNT_W'(1);
        end
    end

    assign q      = r_q;
    assign is_one = (r_q == CNT_W'(1));

endmodule

// File: rtl/blit_cnt.sv
// Blitter loop-count sequencer: latches COUNT, runs the inner/outer loop,
// handshakes pixel steps with the datapath and pulses outer_step/blit_done.
// Optional feature: define BLIT_CNT_RDBACK_EN to expose the live inner count
// in the upper half of the status word.
module blit_cnt
    import blit_cnt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic        countld,
    input  logic        cmdld,
    input  logic        stopld,
    input  logic        statrd,
    input  logic [31:0] gpu_din,
    input  logic        step,
    output logic        step_rdy,
    output logic        busy,
    output logic        outer_step,
    output logic        blit_done,
    output logic [31:0] stat_dout
);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_inner_ld;
    logic [CNT_W-1:0] r_outer_ld;
    logic [CNT_W-1:0] w_icnt;
    logic [CNT_W-1:0] w_ocnt;
    logic [CNT_W-1:0] w_rdback;
    logic             w_icnt_one;
    logic             w_ocnt_one;
    logic             w_i_ld;
    logic             w_i_dec;
    logic             w_o_ld;
    logic             w_o_dec;
    logic             w_last;
    logic             r_busy;
    logic             r_outer_step;
    logic             r_blit_done;
    logic [31:0]      w_stat;

    // COUNT latches: only writable while the sequencer is idle
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_inner_ld <= '0;
            r_outer_ld <= '0;
        end else if (countld && (r_state == IDLE)) begin
            r_inner_ld <= gpu_din[CNT_W-1:0];
            r_outer_ld <= gpu_din[COUNT_OUTER_LSB +: CNT_W];
        end
    end

    blit_cnt_dcr #(.CNT_W(CNT_W)) u_icnt (
        .clk    (clk),
        .resetl (resetl),
        .ld     (w_i_ld),
        .dec    (w_i_dec),
        .d      (r_inner_ld),
        .q      (w_icnt),
        .is_one (w_icnt_one)
    );

    blit_cnt_dcr #(.CNT_W(CNT_W)) u_ocnt (
        .clk    (clk),
        .resetl (resetl),
        .ld     (w_o_ld),
        .dec    (w_o_dec),
        .d      (r_outer_ld),
        .q      (w_ocnt),
        .is_one (w_ocnt_one)
    );

    // State register
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and counter control; stop takes precedence over a step
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        w_next  = r_state;
        w_i_ld  = 1'b0;
        w_i_dec = 1'b0;
        w_o_ld  = 1'b0;
        w_o_dec = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmdld) begin
                    w_next = RUN;
                    w_i_ld = 1'b1;
                    w_o_ld = 1'b1;
                end
            end
            RUN: begin
                if (stopld) begin
                    w_next = IDLE;
                end else if (step) begin
                    w_i_dec = 1'b1;
                    if (w_icnt_one) begin
                        if (w_ocnt_one) begin
                            w_next = IDLE;
                            w_last = 1'b1;
                        end else begin
                            w_next = OUTER;
                        end
                    end
                end
            end
            OUTER: begin
                if (stopld) begin
                    w_next = IDLE;
                end else begin
                    w_o_dec = 1'b1;
                    w_i_ld  = 1'b1;
                    w_next  = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered status outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_busy       <= 1'b0;
            r_outer_step <= 1'b0;
            r_blit_done  <= 1'b0;
        end else begin
            r_busy       <= (w_next != IDLE);
            r_outer_step <= (w_next == OUTER);
            r_blit_done  <= w_last;
        end
    end

`ifdef BLIT_CNT_RDBACK_EN
    assign w_rdback = w_icnt;
`else
    assign w_rdback = '0;
`endif

    // Status read mux: zero unless the read strobe is active
    always_comb begin
        w_stat                          = '0;
        w_stat[STAT_IDLE_BIT]           = ~r_busy;
        w_stat[STAT_OUTER_BIT]          = (r_state == OUTER);
        w_stat[STAT_CNT_LSB +: CNT_W]   = w_rdback;
        stat_dout                       = statrd ? w_stat : 32'h0;
    end

    assign step_rdy   = (r_state == RUN);
    assign busy       = r_busy;
    assign outer_step = r_outer_step;
    assign blit_done  = r_blit_done;

endmodule

// File: tb/tb_blit_cnt.sv
// Self-checking bench for blit_cnt (built with CNT_W = 4 so full-range
// counts stay short). Expected step/outer totals per blit go into a
// scoreboard queue at cmdld and are compared when blit_done pulses.
module tb_blit_cnt;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        resetl;
    logic        countld;
    logic        cmdld;
    logic        stopld;
    logic        statrd;
    logic [31:0] gpu_din;
    logic        step;
    logic        step_rdy;
    logic        busy;
    logic        outer_step;
    logic        blit_done;
    logic [31:0] stat_dout;

    blit_cnt #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetl     (resetl),
        .countld    (countld),
        .cmdld      (cmdld),
        .stopld     (stopld),
        .statrd     (statrd),
        .gpu_din    (gpu_din),
        .step       (step),
        .step_rdy   (step_rdy),
        .busy       (busy),
        .outer_step (outer_step),
        .blit_done  (blit_done),
        .stat_dout  (stat_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] count;
        int          steps;
        int          outers;
    } vec_t;

    typedef struct {
        int steps;
        int outers;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   acc    = 0;
    int   outs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] count);
        countld = 1'b1;
        gpu_din = count;
        tick();
        countld = 1'b0;
        gpu_din = 32'h0;
    endtask

    task automatic start(input bit push, input int steps, input int outers);
        exp_t e;
        e.steps  = steps;
        e.outers = outers;
        cmdld = 1'b1;
        if (push) sb_q.push_back(e);
        tick();
        cmdld = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (blit_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    // Monitor: count accepted steps and outer pulses, score each finished blit
    always @(negedge clk) begin
        if (resetl) begin
            if (cmdld && !busy) begin
                acc  = 0;
                outs = 0;
            end
            if (step && step_rdy) acc++;
            if (outer_step) outs++;
            if (blit_done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_steps", 32'(acc), 32'(e.steps));
                    check("sb_outers", 32'(outs), 32'(e.outers));
                end
                acc  = 0;
                outs = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_stat;
        int          done_before;

        vecs[0] = '{32'h0002_0003, 6, 1};
        vecs[1] = '{32'h0001_0000, 16, 0};
        vecs[2] = '{32'h0001_0001, 1, 0};
        vecs[3] = '{32'h0003_0001, 3, 2};
        vecs[4] = '{32'h0000_0002, 32, 15};
        vecs[5] = '{32'hABC2_DEF3, 6, 1};
        vecs[6] = '{32'h0002_000F, 30, 1};

        resetl  = 1'b0;
        countld = 1'b0;
        cmdld   = 1'b0;
        stopld  = 1'b0;
        statrd  = 1'b0;
        gpu_din = 32'h0;
        step    = 1'b0;
        repeat (2) tick();
        resetl = 1'b1;
        tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step_rdy", 32'(step_rdy), 32'd0);
        check("rst_outer_step", 32'(outer_step), 32'd0);
        check("rst_blit_done", 32'(blit_done), 32'd0);
        check("rst_stat_off", stat_dout, 32'h0);
        statrd = 1'b1;
        #1;
        check("rst_stat_on", stat_dout, 32'h0000_0001);
        statrd = 1'b0;

        // Hand sequence: 3 x 2 blit, cycle by cycle
        load(32'h0002_0003);
        start(1'b1, 6, 1);
        check("t1_rdy_after_cmd", 32'(step_rdy), 32'd1);
        check("t1_busy_after_cmd", 32'(busy), 32'd1);
        step = 1'b1;
        repeat (3) tick();
        check("t1_outer_rdy", 32'(step_rdy), 32'd0);
        check("t1_outer_pulse", 32'(outer_step), 32'd1);
        statrd = 1'b1;
        #1;
        check("t1_outer_stat", stat_dout, 32'h0000_0002);
        statrd = 1'b0;
        tick();
        check("t1_run_again", 32'(step_rdy), 32'd1);
        check("t1_outer_drop", 32'(outer_step), 32'd0);
        repeat (3) tick();
        check("t1_done", 32'(blit_done), 32'd1);
        check("t1_busy_clear", 32'(busy), 32'd0);
        check("t1_rdy_clear", 32'(step_rdy), 32'd0);
        step = 1'b0;
        tick();
        check("t1_done_1cyc", 32'(blit_done), 32'd0);

        // Table-driven blits with continuous step
        for (int v = 0; v < 7; v++) begin
            load(vecs[v].count);
            start(1'b1, vecs[v].steps, vecs[v].outers);
            step = 1'b1;
            wait_done(600);
            step = 1'b0;
            check("tbl_busy_after", 32'(busy), 32'd0);
            tick();
            check("tbl_done_1cyc", 32'(blit_done), 32'd0);
        end

        // Abort after two steps: no done, inner count frozen at 3
        load(32'h0001_0005);
        start(1'b0, 0, 0);
        done_before = n_done;
        step = 1'b1;
        repeat (2) tick();
        step   = 1'b0;
        stopld = 1'b1;
        tick();
        stopld = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_rdy", 32'(step_rdy), 32'd0);
        statrd = 1'b1;
        #1;
`ifdef BLIT_CNT_RDBACK_EN
        exp_stat = 32'h0003_0001;
`else
        exp_stat = 32'h0000_0001;
`endif
        check("stop_stat", stat_dout, exp_stat);
        statrd = 1'b0;
        #1;
        check("stat_gated", stat_dout, 32'h0);
        repeat (4) tick();
        check("stop_no_done", 32'(n_done), 32'(done_before));

        // COUNT write while busy is ignored; the next blit reuses the old count
        load(32'h0001_0002);
        start(1'b1, 2, 0);
        step    = 1'b1;
        countld = 1'b1;
        gpu_din = 32'h0009_0009;
        tick();
        countld = 1'b0;
        gpu_din = 32'h0;
        cmdld   = 1'b1;
        tick();
        cmdld = 1'b0;
        wait_done(20);
        step = 1'b0;
        tick();
        start(1'b1, 2, 0);
        step = 1'b1;
        wait_done(200);
        step = 1'b0;
        tick();

        // Asynchronous reset while in OUTER, then blit from the cleared count
        load(32'h0003_0002);
        start(1'b0, 0, 0);
        step = 1'b1;
        repeat (2) tick();
        check("pre_rst_outer", 32'(outer_step), 32'd1);
        #2;
        resetl = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_outer_step", 32'(outer_step), 32'd0);
        check("arst_step_rdy", 32'(step_rdy), 32'd0);
        check("arst_blit_done", 32'(blit_done), 32'd0);
        check("arst_stat", stat_dout, 32'h0);
        step = 1'b0;
        tick();
        resetl = 1'b1;
        tick();
        start(1'b1, 256, 15);
        step = 1'b1;
        wait_done(400);
        step = 1'b0;
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
